conv_mac_unit: RTL
==================

CONV_MAC_UNIT -- requirements
Module: conv_mac_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed width of the input, weight, bias and output words.
REQ-002 SHALL have parameter ACC_W, default 32: signed accumulator width.
REQ-003 SHALL have parameter ADDR_W, default 16: width of the save address.
REQ-004 SHALL have parameter BIAS_SHIFT, default 0: left shift applied to the bias at accumulator init.
REQ-005 SHALL have parameter OUT_SHIFT, default 7: arithmetic right shift applied before saturation; must be at least 1.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port en_ctrl, input, 1 bit: global enable; while low, all state holds.
REQ-009 SHALL have port en_mac, input, 1 bit: operand pair valid; accumulate this cycle.
REQ-010 SHALL have ports s_data, w_data, b_data, input, DATA_W bits each, signed: input word, weight word and bias word.
REQ-011 SHALL have port en_sat, input, 1 bit: shift and saturate the accumulator.
REQ-012 SHALL have port en_write, input, 1 bit: commit the saturated result.
REQ-013 SHALL have port save_addr, input, ADDR_W bits: output address, sampled with en_write.
REQ-014 SHALL have port finish, input, 1 bit: the whole convolution is complete.
REQ-015 SHALL have ports mem_we (output, 1 bit), mem_waddr (output, ADDR_W bits) and mem_wdata (output, DATA_W bits): the output-memory write port.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-017 SHALL have ports busy, sat_flag and protocol_err, output, 1 bit each: status; sat_flag and protocol_err are sticky.
REQ-018 SHALL have port mac_count, output, 16 bits: number of MACs since the last accumulator init.

Function
REQ-019 SHALL implement a state machine with states IDLE, ACCUM, SATURATE, WRITE and DONE.
REQ-020 SHALL evaluate state transitions and datapath updates only in cycles where en_ctrl=1; cycles with en_ctrl=0 are full stalls with no output change, except that mem_we and done SHALL deassert.
REQ-021 SHALL, on en_mac in IDLE or WRITE, set acc = sext(b_data)<<BIAS_SHIFT + 2^(OUT_SHIFT-1) + s_data*w_data, set mac_count=1 and move to ACCUM; the bias is sampled on this first en_mac only.
REQ-022 SHALL, on en_mac in ACCUM, set acc = acc + s_data*w_data (signed product sign-extended to ACC_W, result wraps modulo 2^ACC_W) and increment mac_count, saturating mac_count at 0xFFFF.
REQ-023 SHALL, on en_sat in ACCUM, compute r = acc >>> OUT_SHIFT, clip r to [-2^(DATA_W-1), 2^(DATA_W-1)-1], store it in sat_q, set sat_flag if clipping occurred, and move to SATURATE.
REQ-024 SHALL, on en_write in SATURATE, capture save_addr and assert mem_we=1 for exactly one cycle on the next cycle, with mem_waddr equal to the captured address and mem_wdata=sat_q, and move to WRITE.
REQ-025 SHALL hold mem_waddr and mem_wdata stable after the write; mem_we SHALL otherwise be 0.
REQ-026 SHALL, on finish in IDLE, ACCUM or WRITE, move to DONE, pulse done for one cycle, then return to IDLE; an accumulation in flight in ACCUM is discarded.
REQ-027 SHALL resolve simultaneous inputs with priority finish > en_write > en_sat > en_mac; each lower-priority strobe that is asserted in the same cycle SHALL set protocol_err.
REQ-028 SHALL set protocol_err on: en_mac in SATURATE; en_sat outside ACCUM; en_write outside SATURATE. The offending strobe SHALL be ignored and the state SHALL not change.
REQ-029 SHALL drive busy=1 in every state except IDLE.
REQ-030 SHALL clear sat_flag and protocol_err only on reset.

Reset
REQ-031 SHALL, while reset=0, asynchronously force state=IDLE and acc, sat_q, mac_count, mem_we, mem_waddr, mem_wdata, done, busy, sat_flag and protocol_err to 0.
REQ-032 SHALL, when reset is asserted mid-operation, abort any write still to be issued, and SHALL NOT issue it after release.
REQ-033 SHALL begin accepting strobes on the first rising edge after reset deasserts.

Verification
REQ-034 Bench SHALL cover a basic window: b_data=2; 3 en_mac cycles with s=10, w=10; en_sat; en_write with save_addr=0x0005 -> acc=366 and mac_count=3; next cycle mem_we=1, mem_waddr=0x0005, mem_wdata=0x02, sat_flag=0.
REQ-035 Bench SHALL cover positive saturation: b_data=0; 100 en_mac cycles with s=127, w=127; en_sat; en_write -> mem_wdata=0x7F, sat_flag=1.
REQ-036 Bench SHALL cover negative saturation: b_data=0; 10 en_mac cycles with s=-128, w=127; en_sat; en_write -> mem_wdata=0x80, sat_flag=1.
REQ-037 Bench SHALL cover a stall: en_ctrl=0 for 5 cycles between MACs -> acc and mac_count unchanged, final result identical to the unstalled run.
REQ-038 Bench SHALL cover protocol errors: en_write while in ACCUM -> protocol_err=1, no mem_we, state stays ACCUM; en_sat and en_write in the same cycle in SATURATE -> the write occurs and protocol_err=1.
REQ-039 Bench SHALL cover reset during SATURATE followed by finish after release -> no mem_we at any point, all outputs 0 after reset, one done pulse, return to IDLE.

Source files
------------

// File: rtl/conv_mac_unit_if.sv
// Strobe, operand, output-memory and status bundle for conv_mac_unit.
interface conv_mac_unit_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
);
    logic                     en_ctrl;
    logic                     en_mac;
    logic signed [DATA_W-1:0] s_data;
    logic signed [DATA_W-1:0] w_data;
    logic signed [DATA_W-1:0] b_data;
    logic                     en_sat;
    logic                     en_write;
    logic [ADDR_W-1:0]        save_addr;
    logic                     finish;

    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_waddr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     done;
    logic                     busy;
    logic                     sat_flag;
    logic                     protocol_err;
    logic [15:0]              mac_count;

    // Sequencer side: drives strobes and operands, observes results.
    modport master (
        output en_ctrl, en_mac, s_data, w_data, b_data, en_sat, en_write, save_addr, finish,
        input  mem_we, mem_waddr, mem_wdata, done, busy, sat_flag, protocol_err, mac_count
    );

    // MAC unit side.
    modport slave (
        input  en_ctrl, en_mac, s_data, w_data, b_data, en_sat, en_write, save_addr, finish,
        output mem_we, mem_waddr, mem_wdata, done, busy, sat_flag, protocol_err, mac_count
    );
endinterface

// File: rtl/conv_mac_unit.sv
// Convolution multiply-accumulate unit: bias init, MAC accumulation,
// rounding shift with saturation, and a single-cycle output-memory write.
module conv_mac_unit #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned BIAS_SHIFT = 0,
    parameter int unsigned OUT_SHIFT  = 7
) (
    input  logic            clk,
    input  logic            reset,
    conv_mac_unit_if.slave  bus
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = 16;

    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(1) <<< (OUT_SHIFT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [CNT_W-1:0]        CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SATURATE,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]        sat_q, sat_d;
    logic [CNT_W-1:0]         mac_count_q, mac_count_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]        mem_waddr_q, mem_waddr_d;
    logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     sat_flag_q, sat_flag_d;
    logic                     protocol_err_q, protocol_err_d;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  mac_term_c;
    logic signed [ACC_W-1:0]  bias_c;
    logic signed [ACC_W-1:0]  shifted_c;
    logic                     clip_hi_c;
    logic                     clip_lo_c;
    logic [DATA_W-1:0]        sat_word_c;

    // Signed product, sign-extended bias and the clipped rounding result.
    assign prod_c     = PROD_W'(bus.s_data) * PROD_W'(bus.w_data);
    assign mac_term_c = ACC_W'(prod_c);
    assign bias_c     = ACC_W'(bus.b_data) <<< BIAS_SHIFT;
    assign shifted_c  = acc_q >>> OUT_SHIFT;
    assign clip_hi_c  = shifted_c > SAT_MAX;
    assign clip_lo_c  = shifted_c < SAT_MIN;
    assign sat_word_c = clip_hi_c ? DATA_W'(SAT_MAX) :
                        clip_lo_c ? DATA_W'(SAT_MIN) : DATA_W'(shifted_c);

    // Next-state and datapath: one winning strobe per cycle (finish > write > sat > mac).
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        sat_d          = sat_q;
        mac_count_d    = mac_count_q;
        mem_we_d       = 1'b0;
        mem_waddr_d    = mem_waddr_q;
        mem_wdata_d    = mem_wdata_q;
        done_d         = 1'b0;
        sat_flag_d     = sat_flag_q;
        protocol_err_d = protocol_err_q;

        if (bus.en_ctrl) begin
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end

            if (bus.finish) begin
                if (bus.en_write || bus.en_sat || bus.en_mac) begin
                    protocol_err_d = 1'b1;
                end
                if (state_q inside {ST_IDLE, ST_ACCUM, ST_WRITE}) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else if (bus.en_write) begin
                if (bus.en_sat || bus.en_mac) begin
                    protocol_err_d = 1'b1;
                end
                if (state_q == ST_SATURATE) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = bus.save_addr;
                    mem_wdata_d = sat_q;
                    state_d     = ST_WRITE;
                end else begin
                    protocol_err_d = 1'b1;
                end
            end else if (bus.en_sat) begin
                if (bus.en_mac) begin
                    protocol_err_d = 1'b1;
                end
                if (state_q == ST_ACCUM) begin
                    sat_d   = sat_word_c;
                    state_d = ST_SATURATE;
                    if (clip_hi_c || clip_lo_c) begin
                        sat_flag_d = 1'b1;
                    end
                end else begin
                    protocol_err_d = 1'b1;
                end
            end else if (bus.en_mac) begin
                case (state_q)
                    ST_IDLE, ST_WRITE: begin
                        acc_d       = bias_c + ROUND_C + mac_term_c;
                        mac_count_d = CNT_W'(1);
                        state_d     = ST_ACCUM;
                    end
                    ST_ACCUM: begin
                        acc_d = acc_q + mac_term_c;
                        if (mac_count_q != CNT_MAX) begin
                            mac_count_d = mac_count_q + CNT_W'(1);
                        end
                    end
                    ST_SATURATE: begin
                        protocol_err_d = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            acc_q          <= '0;
            sat_q          <= '0;
            mac_count_q    <= '0;
            mem_we_q       <= 1'b0;
            mem_waddr_q    <= '0;
            mem_wdata_q    <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            sat_flag_q     <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            sat_q          <= sat_d;
            mac_count_q    <= mac_count_d;
            mem_we_q       <= mem_we_d;
            mem_waddr_q    <= mem_waddr_d;
            mem_wdata_q    <= mem_wdata_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            sat_flag_q     <= sat_flag_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign bus.mem_we       = mem_we_q;
    assign bus.mem_waddr    = mem_waddr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
    assign bus.sat_flag     = sat_flag_q;
    assign bus.protocol_err = protocol_err_q;
    assign bus.mac_count    = mac_count_q;

endmodule
